// File: rtl/debouncer_bank.sv
// rtl/debouncer_bank.sv - multi-channel button debouncer with press/release pulses, long-press and auto-repeat
module debouncer_bank #(
    parameter int N             = 4,
    parameter int DB_CYCLES     = 1000000,
    parameter int HOLD_CYCLES   = 50000000,
    parameter int REPEAT_CYCLES = 10000000,
    parameter int ACTIVE_LOW    = 0
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic [N-1:0] i_btn,
    output logic [N-1:0] o_state,
    output logic [N-1:0] o_down,
    output logic [N-1:0] o_up,
    output logic [N-1:0] o_long,
    output logic [N-1:0] o_rpt
);

    localparam int DW   = (DB_CYCLES < 1) ? 1 : $clog2(DB_CYCLES + 1);
    localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int HW   = (HMAX < 1) ? 1 : $clog2(HMAX + 1);

    localparam logic [DW-1:0] DB_LAST  = DW'(DB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_VAL = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] REP_VAL  = HW'(REPEAT_CYCLES);
    localparam logic          AL_BIT   = (ACTIVE_LOW != 0);
    localparam logic          REP_EN   = (REPEAT_CYCLES > 0);

    typedef enum logic [1:0] {
        H_IDLE,
        H_PRESS,
        H_HELD
    } hold_t;

    for (genvar g = 0; g < N; g++) begin : g_ch
        logic [1:0]    r_sync;
        logic [DW-1:0] r_dcnt;
        logic          r_state;
        logic          r_down;
        logic          r_up;
        logic          r_long;
        logic          r_rpt;
        hold_t         r_hst;
        logic [HW-1:0] r_hcnt;

        logic w_b;
        logic w_s;
        logic w_flip;
        logic w_rise;
        logic w_fall;

        // Inversion happens before the synchroniser so the reset value 0 always means "not pressed".
        assign w_b    = i_btn[g] ^ AL_BIT;
        assign w_s    = r_sync[1];
        assign w_flip = (w_s != r_state) && (r_dcnt == DB_LAST);
        assign w_rise = w_flip & w_s;
        assign w_fall = w_flip & ~w_s;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_sync  <= '0;
                r_dcnt  <= '0;
                r_state <= 1'b0;
                r_down  <= 1'b0;
                r_up    <= 1'b0;
            end else begin
                r_sync <= {r_sync[0], w_b};
                r_down <= w_rise;
                r_up   <= w_fall;
                if (w_s == r_state) begin
                    r_dcnt <= '0;
                end else if (r_dcnt == DB_LAST) begin
                    r_state <= w_s;
                    r_dcnt  <= '0;
                end else begin
                    r_dcnt <= r_dcnt + DW'(1);
                end
            end
        end

        // Hold tracking keys off the same-edge debounce decision so a release beats long/rpt.
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_hst  <= H_IDLE;
                r_hcnt <= '0;
                r_long <= 1'b0;
                r_rpt  <= 1'b0;
            end else begin
                r_long <= 1'b0;
                r_rpt  <= 1'b0;
                case (r_hst)
                    H_IDLE: begin
                        if (w_rise) begin
                            r_hst  <= H_PRESS;
                            r_hcnt <= HW'(1);
                        end
                    end
                    H_PRESS: begin
                        if (w_fall) begin
                            r_hst  <= H_IDLE;
                            r_hcnt <= '0;
                        end else if (r_hcnt == HOLD_VAL) begin
                            r_long <= 1'b1;
                            r_hst  <= H_HELD;
                            r_hcnt <= HW'(1);
                        end else begin
                            r_hcnt <= r_hcnt + HW'(1);
                        end
                    end
                    H_HELD: begin
                        if (w_fall) begin
                            r_hst  <= H_IDLE;
                            r_hcnt <= '0;
                        end else if (REP_EN && (r_hcnt == REP_VAL)) begin
                            r_rpt  <= 1'b1;
                            r_hcnt <= HW'(1);
                        end else if (REP_EN) begin
                            r_hcnt <= r_hcnt + HW'(1);
                        end
                    end
                    default: begin
                        r_hst  <= H_IDLE;
                        r_hcnt <= '0;
                    end
                endcase
            end
        end

        assign o_state[g] = r_state;
        assign o_down[g]  = r_down;
        assign o_up[g]    = r_up;
        assign o_long[g]  = r_long;
        assign o_rpt[g]   = r_rpt;
    end

endmodule

// File: tb/tb_debouncer_bank.sv
// tb/tb_debouncer_bank.sv - scoreboard bench for debouncer_bank (active-high and active-low instances)
module tb_debouncer_bank;

    localparam int K_DOWN = 0;
    localparam int K_UP   = 1;
    localparam int K_LONG = 2;
    localparam int K_RPT  = 3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] btn = 2'b00;
    logic [1:0] btn_al = 2'b11;

    logic [1:0] st_h, dn_h, up_h, lg_h, rp_h;
    logic [1:0] st_l, dn_l, up_l, lg_l, rp_l;

    int edge_cnt = 0;
    int n_cmp = 0;
    int n_mis = 0;

    typedef struct {
        int cyc;
        int ch;
        int kind;
    } ev_t;
    ev_t exp_q[$];

    debouncer_bank #(
        .N(2), .DB_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .ACTIVE_LOW(0)
    ) u_dut_h (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn),
        .o_state(st_h), .o_down(dn_h), .o_up(up_h), .o_long(lg_h), .o_rpt(rp_h)
    );

    debouncer_bank #(
        .N(2), .DB_CYCLES(4), .HOLD_CYCLES(10), .REPEAT_CYCLES(3), .ACTIVE_LOW(1)
    ) u_dut_l (
        .i_clk(clk), .i_rst_n(rst_n), .i_btn(btn_al),
        .o_state(st_l), .o_down(dn_l), .o_up(up_l), .o_long(lg_l), .o_rpt(rp_l)
    );

    always #5 clk = ~clk;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input int cyc, input int ch, input int kind);
        ev_t e;
        e.cyc  = cyc;
        e.ch   = ch;
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int e);
        do @(negedge clk); while (edge_cnt - 1 < e);
    endtask

    function automatic logic [3:0] pulses(input int k);
        case (k)
            K_DOWN:  return {dn_l, dn_h};
            K_UP:    return {up_l, up_h};
            K_LONG:  return {lg_l, lg_h};
            default: return {rp_l, rp_h};
        endcase
    endfunction

    // Every observed pulse must match (and consume) a scoreboard entry for this exact edge.
    always @(negedge clk) begin
        int last;
        int idx;
        int hot;
        logic [3:0] pv;
        last = edge_cnt - 1;
        for (int c = 0; c < 4; c++) begin
            hot = 0;
            for (int k = 0; k < 4; k++) begin
                pv = pulses(k);
                if (pv[c]) begin
                    hot++;
                    idx = -1;
                    for (int j = 0; j < exp_q.size(); j++)
                        if (idx < 0 && exp_q[j].cyc == last && exp_q[j].ch == c && exp_q[j].kind == k)
                            idx = j;
                    n_cmp++;
                    assert (idx >= 0) else begin
                        n_mis++;
                        $error("FAIL unexpected_pulse: observed kind %0d ch %0d at edge %0d expected none", k, c, last);
                    end
                    if (idx >= 0) exp_q.delete(idx);
                end
            end
            if (hot > 0) chk($sformatf("one_hot_ch%0d", c), hot, 1);
        end
    end

    initial begin
        int e0, e1, es, r;

        // Reset held: everything low, including the active-low instance whose raw inputs idle high.
        repeat (3) @(negedge clk);
        chk("rst_state", {st_l, st_h}, 0);
        chk("rst_pulses", {dn_l, dn_h, up_l, up_h, lg_l, lg_h, rp_l, rp_h}, 0);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        chk("idle_state", {st_l, st_h}, 0);
        chk("idle_queue", exp_q.size(), 0);

        // Clean press on ch0 held through long and repeats, then released.
        e0 = edge_cnt;
        btn = 2'b01;
        push(e0 + 5, 0, K_DOWN);
        push(e0 + 15, 0, K_LONG);
        push(e0 + 18, 0, K_RPT);
        push(e0 + 21, 0, K_RPT);
        repeat (5) @(negedge clk);
        chk("state_before_latency", st_h, 2'b00);
        @(negedge clk);
        chk("state_after_latency", st_h, 2'b01);
        wait_to(e0 + 22);
        e1 = edge_cnt;
        btn = 2'b00;
        for (int t = e0 + 24; t < e1 + 5; t += 3) push(t, 0, K_RPT);
        push(e1 + 5, 0, K_UP);
        wait_to(e1 + 8);
        #1;
        chk("clean_press_drained", exp_q.size(), 0);
        chk("clean_release_state", st_h, 2'b00);

        // Bouncy press on ch1, released so the up edge lands on the would-be long edge.
        repeat (3) @(negedge clk);
        btn = 2'b10;
        @(negedge clk) btn = 2'b00;
        @(negedge clk) btn = 2'b10;
        @(negedge clk) btn = 2'b00;
        @(negedge clk) btn = 2'b10;
        es = edge_cnt;
        push(es + 5, 1, K_DOWN);
        push(es + 15, 1, K_UP);
        repeat (4) @(negedge clk);
        chk("bounce_not_yet", st_h, 2'b00);
        repeat (6) @(negedge clk);
        btn = 2'b00;
        wait_to(es + 18);
        #1;
        chk("bounce_drained", exp_q.size(), 0);
        chk("bounce_release_state", st_h, 2'b00);

        // Both channels pressed together; short press on the active-low instance.
        repeat (3) @(negedge clk);
        e0 = edge_cnt;
        btn = 2'b11;
        btn_al = 2'b10;
        push(e0 + 5, 0, K_DOWN);
        push(e0 + 5, 1, K_DOWN);
        push(e0 + 5, 2, K_DOWN);
        push(e0 + 15, 0, K_LONG);
        push(e0 + 15, 1, K_LONG);
        repeat (8) @(negedge clk);
        btn_al = 2'b11;
        push(e0 + 13, 2, K_UP);
        wait_to(e0 + 16);
        #1;
        chk("dual_drained", exp_q.size(), 0);
        chk("dual_held_state", {st_l, st_h}, 4'b0011);

        // Reset in the middle of HELD, then release with both buttons still pressed.
        #1 rst_n = 1'b0;
        #1;
        chk("midhold_rst_state", {st_l, st_h}, 0);
        chk("midhold_rst_down", {dn_l, dn_h}, 0);
        chk("midhold_rst_up", {up_l, up_h}, 0);
        chk("midhold_rst_long", {lg_l, lg_h}, 0);
        chk("midhold_rst_rpt", {rp_l, rp_h}, 0);
        repeat (3) @(negedge clk);
        chk("in_rst_state", {st_l, st_h}, 0);
        rst_n = 1'b1;
        r = edge_cnt;
        push(r + 5, 0, K_DOWN);
        push(r + 5, 1, K_DOWN);
        repeat (5) @(negedge clk);
        chk("post_rst_not_yet", st_h, 2'b00);
        wait_to(r + 8);
        #1;
        chk("post_rst_drained", exp_q.size(), 0);
        chk("post_rst_state", {st_l, st_h}, 4'b0011);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/debouncer_bank.md
# debouncer_bank

Parametrised multi-channel button debouncer with press/release edge pulses, long-press detection and auto-repeat. Each channel synchronises a raw asynchronous button input and applies symmetric debouncing on both press and release. It emits one-cycle event pulses and a debounced level per channel. It sits between the board push-buttons and the front-panel/UI control logic, and replaces per-button single-channel debouncers.

## Interface
- `N`, 4: number of independent channels.
- `DB_CYCLES`, 1000000: consecutive cycles a synchronised input must differ from the debounced state before the state flips; ≥1.
- `HOLD_CYCLES`, 50000000: cycles after `down` at which `long` pulses; ≥1.
- `REPEAT_CYCLES`, 10000000: period of `rpt` pulses after `long`; 0 disables repeat.
- `ACTIVE_LOW`, 0: 1 = raw inputs are pressed-low; they are inverted before synchronisation.

- `clk` in 1: single clock, all logic on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `btn` in N: raw button inputs, asynchronous to `clk`.
- `state` out N: debounced level, 1 = pressed.
- `down` out N: 1-cycle pulse on debounced press.
- `up` out N: 1-cycle pulse on debounced release.
- `long` out N: 1-cycle pulse when held `HOLD_CYCLES` after `down`.
- `rpt` out N: 1-cycle auto-repeat pulse.

## Operation
- All outputs are registered. All outputs, sync flops and counters are 0 while `rst_n`=0. Reset asserts immediately and releases on the next edge.
- Per channel, `b = btn[i] ^ ACTIVE_LOW` passes through a 2-flop synchroniser to give `s`. The sync flops reset to 0, which is the not-pressed level.
- Debounce counter `dcnt` is `$clog2(DB_CYCLES+1)` bits wide and updates each edge:
  - If `s == state[i]`: `dcnt <= 0`. Any agreeing cycle, such as a bounce, restarts the count.
  - Else if `dcnt == DB_CYCLES-1`: `state[i] <= s`, `dcnt <= 0`. Pulse `down[i]` if `s`=1, or `up[i]` if `s`=0, on the same edge.
  - Else: `dcnt <= dcnt+1`.
- Hold FSM per channel has states IDLE, PRESS and HELD. Hold counter `hcnt` is sized for `max(HOLD_CYCLES, REPEAT_CYCLES)`.
  - IDLE: left on the `down` edge to PRESS with `hcnt <= 1`.
  - PRESS: `hcnt` increments each cycle. When `hcnt == HOLD_CYCLES` and the state stays 1, pulse `long[i]`, go to HELD, set `hcnt <= 1`.
  - HELD: if `REPEAT_CYCLES`>0 and `hcnt == REPEAT_CYCLES`, pulse `rpt[i]` and set `hcnt <= 1`; else increment. If `REPEAT_CYCLES`=0, `hcnt` holds and `rpt` never asserts.
  - A release (`up` edge) from PRESS or HELD goes to IDLE and clears `hcnt`. The release wins over a simultaneous `long`/`rpt`, so neither pulses on the `up` edge.
- Channels are fully independent. Simultaneous events on different channels all pulse in the same cycle.
- At most one of `down`/`up`/`long`/`rpt` is high per channel per cycle.
- If `btn` is held through reset release, the channel behaves as a fresh press. `down` pulses after the normal debounce latency.

## Timing
- Latency: let E0 be the first edge sampling a new stable level at `btn`. `state` changes and `down`/`up` pulses after edge E0+DB_CYCLES+1.
- If `down` is at cycle t, `long` is at t+HOLD_CYCLES and `rpt` is at t+HOLD_CYCLES+m·REPEAT_CYCLES for m≥1, while still pressed.
- Every pulse is exactly one cycle wide. `state` is stable for at least DB_CYCLES cycles between flips.
- Asserting reset mid-count or mid-hold clears all outputs asynchronously; no pulse is emitted.
- A glitch shorter than DB_CYCLES cycles, counted after synchronisation, produces no output change.

## Test plan
Use N=2, DB_CYCLES=4, HOLD_CYCLES=10, REPEAT_CYCLES=3, ACTIVE_LOW=0 unless noted.
- Clean press on ch0 first sampled at edge 0, held → `state[0]` and `down[0]` high after edge 5, `down[0]` low after edge 6. `long[0]` is at edge 15, `rpt[0]` at edges 18 and 21. ch1 stays all-zero.
- Bouncy press (1,0,1,0 for 1 cycle each, then stable 1) → exactly one `down`, 5 edges after stable-1 sampling starts, and no `up`.
- Press for 12 cycles then release → `down`, no `long`, then `up` 5 edges after the 0 level is sampled. Release timed so `up` coincides with the would-be `long` edge → `up` only.
- Both channels pressed on the same edge → `down[1:0]`=2'b11 in the same cycle; `long` on both in the same cycle.
- ACTIVE_LOW=1 with btn idle at 1 after reset → no events. Drive 0 → `down` after 5 edges.
- Pull `rst_n` low during HELD → all outputs 0 immediately. Release reset with button still pressed → `down` again after the debounce latency.
